// File: rtl/mem_arb_ctrl.sv
// Two-requester arbitrated controller for an internal DEPTH x DATA_W register memory.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module mem_arb_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    localparam int unsigned Depth = 1 << ADDR_W;

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e              state_q;
    logic                owner_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                gnt0_q, gnt1_q, rvalid0_q, rvalid1_q, busy_q;
    logic [DATA_W-1:0]   mem_q [Depth];

    logic                any_req;
    logic                win_d;
    logic                we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;

`ifdef MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        win_d = ~req0;
    end
`else
    logic last_q;

    // last_q names the requester served most recently; the other one wins a tie.
    always_comb begin
        win_d = (req0 & req1) ? ~last_q : ~req0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else if ((state_q != StAccess) && any_req) begin
            last_q <= win_d;
        end
    end
`endif

    always_comb begin
        any_req = req0 | req1;
        we_d    = win_d ? we1 : we0;
        addr_d  = win_d ? addr1 : addr0;
        wdata_d = win_d ? wdata1 : wdata0;
    end

    // DONE arbitrates like IDLE so continuous requests get one access every two cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            busy_q    <= 1'b0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (any_req) begin
                        state_q <= StAccess;
                        owner_q <= win_d;
                        we_q    <= we_d;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        gnt0_q  <= ~win_d;
                        gnt1_q  <= win_d;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                StAccess: begin
                    if (we_q) begin
                        mem_q[addr_q] <= wdata_q;
                    end else begin
                        rdata_q   <= mem_q[addr_q];
                        rvalid0_q <= ~owner_q;
                        rvalid1_q <= owner_q;
                    end
                    state_q <= StDone;
                    busy_q  <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata   = rdata_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Self-checking bench for mem_arb_ctrl: directed steps plus random accesses against a
// memory-array / last-served reference model.
module tb_mem_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [2:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [7:0] rdata;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem_m [8];
    int         last_m;

    logic       op_we [2];
    logic [2:0] op_addr [2];
    logic [7:0] op_data [2];

    always #5 clk = ~clk;

    mem_arb_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .busy(busy)
    );

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mem_m[i] = 8'h00;
        last_m = 1;
    endtask

    task automatic model_apply(input int who, input logic we, input logic [2:0] a,
                               input logic [7:0] d);
        if (we) mem_m[a] = d;
        last_m = who;
    endtask

    function automatic int pick_both();
`ifdef MEM_ARB_FIXED_PRIO_EN
        return 0;
`else
        return (last_m == 1) ? 0 : 1;
`endif
    endfunction

    task automatic set_req(input int who, input logic we, input logic [2:0] a,
                           input logic [7:0] d);
        op_we[who] = we; op_addr[who] = a; op_data[who] = d;
        if (who == 0) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end
    endtask

    // Drop the request and scramble the command fields; the captured command must survive.
    task automatic drop_req(input int who);
        if (who == 0) begin
            req0 = 1'b0; we0 = 1'($urandom); addr0 = 3'($urandom); wdata0 = 8'($urandom);
        end else begin
            req1 = 1'b0; we1 = 1'($urandom); addr1 = 3'($urandom); wdata1 = 8'($urandom);
        end
    endtask

    task automatic chk_gnt(input string tag, input int w);
        chk_b({tag, "_gnt0"}, gnt0, w == 0);
        chk_b({tag, "_gnt1"}, gnt1, w == 1);
        chk_b({tag, "_busy"}, busy, 1'b1);
    endtask

    // Called one cycle after the grant of requester who; checks its rvalid and data.
    task automatic chk_result(input string tag, input int who);
        chk_b({tag, "_nognt0"}, gnt0, 1'b0);
        chk_b({tag, "_nognt1"}, gnt1, 1'b0);
        chk_b({tag, "_rvalid0"}, rvalid0, !op_we[who] && who == 0);
        chk_b({tag, "_rvalid1"}, rvalid1, !op_we[who] && who == 1);
        if (!op_we[who]) chk_d({tag, "_rdata"}, rdata, mem_m[op_addr[who]]);
        model_apply(who, op_we[who], op_addr[who], op_data[who]);
    endtask

    task automatic do_access(input string tag, input int who, input logic we,
                             input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        set_req(who, we, a, d);
        @(posedge clk); #1;
        chk_gnt(tag, who);
        drop_req(who);
        @(posedge clk); #1;
        chk_result(tag, who);
        @(posedge clk); #1;
        chk_b({tag, "_idle"}, busy, 1'b0);
        chk_b({tag, "_rv0_off"}, rvalid0, 1'b0);
        chk_b({tag, "_rv1_off"}, rvalid1, 1'b0);
    endtask

    // Both requesters ask at once; the loser keeps requesting and is granted two cycles later.
    task automatic do_pair(input string tag);
        int w, l;
        @(negedge clk);
        set_req(0, 1'($urandom), 3'($urandom), 8'($urandom));
        set_req(1, 1'($urandom), 3'($urandom), 8'($urandom));
        w = pick_both();
        l = 1 - w;
        @(posedge clk); #1;
        chk_gnt({tag, "_first"}, w);
        drop_req(w);
        @(posedge clk); #1;
        chk_result({tag, "_first"}, w);
        @(posedge clk); #1;
        chk_gnt({tag, "_second"}, l);
        drop_req(l);
        @(posedge clk); #1;
        chk_result({tag, "_second"}, l);
        @(posedge clk); #1;
        chk_b({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_gnt0", gnt0, 1'b0);
        chk_b("rst_gnt1", gnt1, 1'b0);
        chk_b("rst_rvalid0", rvalid0, 1'b0);
        chk_b("rst_rvalid1", rvalid1, 1'b0);
        chk_d("rst_rdata", rdata, 8'h00);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) do_access("rst_read", 0, 1'b0, 3'(i), 8'h00);

        do_access("wr_8f", 0, 1'b1, 3'd3, 8'h8F);
        do_access("rd_8f", 0, 1'b0, 3'd3, 8'h00);
        chk_d("rd_8f_const", rdata, 8'h8F);

        do_access("own_wr", 0, 1'b1, 3'd5, 8'h5A);
        do_access("own_rd", 1, 1'b0, 3'd5, 8'h00);
        chk_d("own_rd_const", rdata, 8'h5A);

        // Reset in the ACCESS cycle of a write: discarded, busy drops at once.
        @(negedge clk);
        set_req(0, 1'b1, 3'd7, 8'hFF);
        @(posedge clk); #1;
        chk_b("midrst_gnt0", gnt0, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk_b("midrst_busy", busy, 1'b0);
        chk_b("midrst_gnt0_off", gnt0, 1'b0);
        drop_req(0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        do_access("midrst_rd7", 0, 1'b0, 3'd7, 8'h00);
        chk_d("midrst_rd7_const", rdata, 8'h00);

        // Continuous contention after reset-fresh pointer: 0,1,0,1 (round-robin).
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        set_req(0, 1'b1, 3'd0, 8'h00);
        set_req(1, 1'b1, 3'd1, 8'h01);
        for (int k = 0; k < 4; k++) begin
            int w;
            w = pick_both();
            @(posedge clk); #1;
            chk_gnt($sformatf("cont%0d", k), w);
            model_apply(w, 1'b1, 3'(w), 8'(w));
            @(posedge clk); #1;
            chk_b($sformatf("cont%0d_gap0", k), gnt0, 1'b0);
            chk_b($sformatf("cont%0d_gap1", k), gnt1, 1'b0);
            if (k == 3) begin
                drop_req(0);
                drop_req(1);
            end
        end
        @(posedge clk); #1;
        chk_b("cont_idle", busy, 1'b0);
`ifndef MEM_ARB_FIXED_PRIO_EN
        chk_b("cont_last_is_1", last_m == 1, 1'b1);
`endif
        do_access("cont_rd0", 0, 1'b0, 3'd0, 8'h00);
        do_access("cont_rd1", 1, 1'b0, 3'd1, 8'h00);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(1, 0) == 0)
                do_access($sformatf("rnd%0d", n), int'($urandom_range(1, 0)), 1'($urandom),
                          3'($urandom), 8'($urandom));
            else
                do_pair($sformatf("pair%0d", n));
        end

        for (int i = 0; i < 8; i++) do_access("final_rd", 1, 1'b0, 3'(i), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
